// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency imem reads,
// buffers {inst, pc} pairs and hands them to decode over valid/ready.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

    logic [31:0] fetch_pc;
    logic [31:0] flight_pc;
    logic        inflight;
    logic        kill;
    logic [AW:0] count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0] q_inst [DEPTH];
    logic [31:0] q_pc   [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic [AW+1:0] used;

    // Credit counts queued entries plus the outstanding read; pops give no credit.
    assign used      = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
    assign issue     = reset && !redirect_valid && (used < LIMIT);
    assign imem_req  = issue;
    assign imem_addr = fetch_pc;

    assign push       = inflight && !kill;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = q_inst[head];
    assign inst_pc    = q_pc[head];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            flight_pc <= '0;
            inflight  <= 1'b0;
            kill      <= 1'b0;
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            kill     <= 1'b1;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            kill     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + 32'd4;
                flight_pc <= fetch_pc;
            end
            if (push) begin
                q_inst[tail] <= imem_data;
                q_pc[tail]   <= flight_pc;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
